// File: rtl/lsu_pkg.sv
// Shared decode codes for the execute / load-store stages.
// Build option for lsu: LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

    localparam int XLEN       = 32;
    localparam int ARGS_WIDTH = 4;

    localparam logic [ARGS_WIDTH-1:0] ALU_TYPE_ADD = 4'd0;
    localparam logic [ARGS_WIDTH-1:0] ALU_TYPE_SUB = 4'd1;
    localparam logic [ARGS_WIDTH-1:0] ALU_TYPE_AND = 4'd2;
    localparam logic [ARGS_WIDTH-1:0] ALU_TYPE_OR  = 4'd3;
    localparam logic [ARGS_WIDTH-1:0] ALU_TYPE_XOR = 4'd4;

    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_NONE = 4'd0;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_LB   = 4'd1;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_LH   = 4'd2;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_LW   = 4'd3;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_LBU  = 4'd4;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_LHU  = 4'd5;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_SB   = 4'd6;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_SH   = 4'd7;
    localparam logic [ARGS_WIDTH-1:0] LSU_TYPE_SW   = 4'd8;

    function automatic logic lsu_is_load(input logic [ARGS_WIDTH-1:0] t);
        return (t == LSU_TYPE_LB)  || (t == LSU_TYPE_LH) ||
               (t == LSU_TYPE_LW)  || (t == LSU_TYPE_LBU) ||
               (t == LSU_TYPE_LHU);
    endfunction

    function automatic logic lsu_is_store(input logic [ARGS_WIDTH-1:0] t);
        return (t == LSU_TYPE_SB) || (t == LSU_TYPE_SH) ||
               (t == LSU_TYPE_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads.
// Purely combinational; halfword/word offsets ignore the low bits.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [ARGS_WIDTH-1:0] lsu_type,
    input  logic [1:0]            off,
    input  logic [XLEN-1:0]       rs2,
    input  logic [XLEN-1:0]       rdata,
    output logic [XLEN-1:0]       wr_data,
    output logic [XLEN/8-1:0]     wr_mask,
    output logic [XLEN-1:0]       ld_data
);

    logic [XLEN-1:0] b_word;
    logic [XLEN-1:0] h_word;

    // Lane shift/mask per store size and extract/extend per load type
    always_comb begin
        wr_data = '0;
        wr_mask = '0;
        ld_data = '0;
        b_word  = rdata >> {off, 3'b000};
        h_word  = rdata >> {off[1], 4'b0000};
        case (lsu_type)
            LSU_TYPE_SB: begin
                wr_data = {4{rs2[7:0]}};
                wr_mask = 4'b0001 << off;
            end
            LSU_TYPE_SH: begin
                wr_data = {2{rs2[15:0]}};
                wr_mask = 4'b0011 << {off[1], 1'b0};
            end
            LSU_TYPE_SW: begin
                wr_data = rs2;
                wr_mask = 4'b1111;
            end
            LSU_TYPE_LB:  ld_data = {{24{b_word[7]}}, b_word[7:0]};
            LSU_TYPE_LBU: ld_data = {24'h0, b_word[7:0]};
            LSU_TYPE_LH:  ld_data = {{16{h_word[15]}}, h_word[15:0]};
            LSU_TYPE_LHU: ld_data = {16'h0, h_word[15:0]};
            LSU_TYPE_LW:  ld_data = rdata;
            default: begin
                wr_data = '0;
                wr_mask = '0;
                ld_data = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and write-back, one outstanding access.
// Optional LSU_MISALIGN_CHECK_EN traps misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst_n,
    input  logic                    i_exu_valid,
    output logic                    o_lsu_ready,
    input  logic [ARGS_WIDTH-1:0]   i_idu_ctr_lsu_type,
    input  logic [DATA_WIDTH-1:0]   i_exu_res,
    input  logic [DATA_WIDTH-1:0]   i_idu_rs2_data,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic [DATA_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_wr_en,
    output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_mem_wr_mask,
    input  logic                    i_mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_resp_data,
    output logic                    o_sys_valid,
    input  logic                    i_sys_ready,
    output logic [DATA_WIDTH-1:0]   o_lsu_res
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic                    o_lsu_misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_e;

    lsu_state_e            state_q;
    logic [ARGS_WIDTH-1:0] type_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rs2_q;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  is_load;
    logic                  is_store;
    logic                  misaligned;

    assign is_load    = lsu_is_load(i_idu_ctr_lsu_type);
    assign is_store   = lsu_is_store(i_idu_ctr_lsu_type);
    assign o_mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
    // Half needs addr[0] clear, word needs addr[1:0] clear
    always_comb begin
        misaligned = 1'b0;
        case (i_idu_ctr_lsu_type)
            LSU_TYPE_LH,
            LSU_TYPE_LHU,
            LSU_TYPE_SH: misaligned = i_exu_res[0];
            LSU_TYPE_LW,
            LSU_TYPE_SW: misaligned = |i_exu_res[1:0];
            default:     misaligned = 1'b0;
        endcase
    end

    // Fault flag raised with the trapped op, cleared when it retires
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            o_lsu_misalign <= 1'b0;
        end else if (state_q == IDLE && i_exu_valid && misaligned) begin
            o_lsu_misalign <= 1'b1;
        end else if (state_q == DONE && i_sys_ready) begin
            o_lsu_misalign <= 1'b0;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    lsu_align u_align (
        .lsu_type (type_q),
        .off      (addr_q[1:0]),
        .rs2      (rs2_q),
        .rdata    (i_mem_resp_data),
        .wr_data  (o_mem_wr_data),
        .wr_mask  (o_mem_wr_mask),
        .ld_data  (ld_data)
    );

    // Accept -> memory request -> response -> hand result to write-back
    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n) begin
            state_q         <= IDLE;
            type_q          <= LSU_TYPE_NONE;
            addr_q          <= '0;
            rs2_q           <= '0;
            o_lsu_ready     <= 1'b1;
            o_mem_req_valid <= 1'b0;
            o_mem_wr_en     <= 1'b0;
            o_sys_valid     <= 1'b0;
            o_lsu_res       <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_exu_valid) begin
                        addr_q      <= i_exu_res;
                        rs2_q       <= i_idu_rs2_data;
                        o_lsu_ready <= 1'b0;
                        if (misaligned) begin
                            type_q      <= LSU_TYPE_NONE;
                            o_sys_valid <= 1'b1;
                            o_lsu_res   <= i_exu_res;
                            state_q     <= DONE;
                        end else if (is_load || is_store) begin
                            type_q          <= i_idu_ctr_lsu_type;
                            o_mem_wr_en     <= is_store;
                            o_mem_req_valid <= 1'b1;
                            state_q         <= REQ;
                        end else begin
                            type_q      <= LSU_TYPE_NONE;
                            o_sys_valid <= 1'b1;
                            o_lsu_res   <= i_exu_res;
                            state_q     <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_resp_valid) begin
                        o_lsu_res   <= o_mem_wr_en ? '0 : ld_data;
                        o_sys_valid <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (i_sys_ready) begin
                        o_sys_valid <= 1'b0;
                        o_lsu_ready <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with an expected-result queue for write-back.
// Misalign steps are built when LSU_MISALIGN_CHECK_EN is defined.
module tb_lsu;
    import lsu_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  exu_valid = 1'b0;
    logic                  lsu_ready;
    logic [ARGS_WIDTH-1:0] lsu_type = '0;
    logic [31:0]           exu_res = '0;
    logic [31:0]           rs2 = '0;
    logic                  req_valid;
    logic                  req_ready = 1'b0;
    logic [31:0]           mem_addr;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [3:0]            wr_mask;
    logic                  resp_valid = 1'b0;
    logic [31:0]           resp_data = '0;
    logic                  sys_valid;
    logic                  sys_ready = 1'b0;
    logic [31:0]           lsu_res;
`ifdef LSU_MISALIGN_CHECK_EN
    logic                  misalign;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    lsu dut (
        .i_sys_clk          (clk),
        .i_sys_rst_n        (rst_n),
        .i_exu_valid        (exu_valid),
        .o_lsu_ready        (lsu_ready),
        .i_idu_ctr_lsu_type (lsu_type),
        .i_exu_res          (exu_res),
        .i_idu_rs2_data     (rs2),
        .o_mem_req_valid    (req_valid),
        .i_mem_req_ready    (req_ready),
        .o_mem_addr         (mem_addr),
        .o_mem_wr_en        (wr_en),
        .o_mem_wr_data      (wr_data),
        .o_mem_wr_mask      (wr_mask),
        .i_mem_resp_valid   (resp_valid),
        .i_mem_resp_data    (resp_data),
        .o_sys_valid        (sys_valid),
        .i_sys_ready        (sys_ready),
        .o_lsu_res          (lsu_res)
`ifdef LSU_MISALIGN_CHECK_EN
        ,
        .o_lsu_misalign     (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [3:0] t,
                                             input logic [31:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (t)
            LSU_TYPE_LB:  return {{24{b[7]}}, b};
            LSU_TYPE_LBU: return {24'h0, b};
            LSU_TYPE_LH:  return {{16{h[15]}}, h};
            LSU_TYPE_LHU: return {16'h0, h};
            default:      return w;
        endcase
    endfunction

    task automatic issue(input logic [3:0] t, input logic [31:0] res,
                         input logic [31:0] d);
        @(negedge clk);
        chk("accept_ready", {31'h0, lsu_ready}, 32'h1);
        exu_valid = 1'b1;
        lsu_type  = t;
        exu_res   = res;
        rs2       = d;
        @(negedge clk);
        exu_valid = 1'b0;
        lsu_type  = '0;
        exu_res   = '0;
        rs2       = '0;
    endtask

    task automatic serve(input int req_dly, input int resp_dly,
                         input logic [31:0] rdata, input logic [31:0] addr,
                         input logic we, input logic [31:0] wd,
                         input logic [3:0] wm);
        chk("req_valid", {31'h0, req_valid}, 32'h1);
        chk("req_addr", mem_addr, addr);
        chk("req_we", {31'h0, wr_en}, {31'h0, we});
        if (we) begin
            chk("req_wdata", wr_data, wd);
            chk("req_wmask", {28'h0, wr_mask}, {28'h0, wm});
        end
        for (int i = 0; i < req_dly; i++) begin
            @(negedge clk);
            chk("bp_req_valid", {31'h0, req_valid}, 32'h1);
            chk("bp_addr", mem_addr, addr);
            chk("bp_we", {31'h0, wr_en}, {31'h0, we});
            chk("bp_ready", {31'h0, lsu_ready}, 32'h0);
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("req_drop", {31'h0, req_valid}, 32'h0);
        for (int i = 0; i < resp_dly; i++) begin
            @(negedge clk);
            chk("wait_no_valid", {31'h0, sys_valid}, 32'h0);
        end
        resp_valid = 1'b1;
        resp_data  = rdata;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
        chk("resp_latency", {31'h0, sys_valid}, 32'h1);
    endtask

    task automatic collect(input int hold);
        logic [31:0] e;
        int n = 0;
        while (!sys_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!sys_valid) begin
            chk("sys_valid_timeout", {31'h0, sys_valid}, 32'h1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", lsu_res, 32'hxxxx_xxxx);
            return;
        end
        e = exp_q.pop_front();
        chk("lsu_res", lsu_res, e);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("no_misalign", {31'h0, misalign}, 32'h0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, sys_valid}, 32'h1);
            chk("hold_res", lsu_res, e);
            chk("hold_ready", {31'h0, lsu_ready}, 32'h0);
        end
        sys_ready = 1'b1;
        @(negedge clk);
        sys_ready = 1'b0;
        chk("valid_drop", {31'h0, sys_valid}, 32'h0);
        chk("ready_back", {31'h0, lsu_ready}, 32'h1);
    endtask

    logic [3:0]  lt[5]  = '{LSU_TYPE_LH, LSU_TYPE_LHU, LSU_TYPE_LW,
                            LSU_TYPE_LB, LSU_TYPE_LHU};
    logic [31:0] la[5]  = '{32'h8000_0102, 32'h8000_0102, 32'h8000_0104,
                            32'h8000_0105, 32'h8000_0100};
    logic [31:0] lw_[5] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h1357_9BDF,
                            32'h0000_F000, 32'h1234_ABCD};

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, lsu_ready}, 32'h1);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rst_sys_valid", {31'h0, sys_valid}, 32'h0);
        chk("rst_res", lsu_res, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_we", {31'h0, wr_en}, 32'h0);
        chk("rst_wdata", wr_data, 32'h0);
        chk("rst_wmask", {28'h0, wr_mask}, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
`endif
        rst_n = 1'b1;

        // pass-through
        exp_q.push_back(32'h1234_5678);
        issue(LSU_TYPE_NONE, 32'h1234_5678, 32'h0);
        chk("pt_latency", {31'h0, sys_valid}, 32'h1);
        chk("pt_no_req", {31'h0, req_valid}, 32'h0);
        collect(0);

        // LB / LBU sign and zero extension
        exp_q.push_back(32'hFFFF_FF80);
        issue(LSU_TYPE_LB, 32'h8000_0003, 32'h0);
        serve(0, 0, 32'h80FF_0011, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        collect(0);
        exp_q.push_back(32'h0000_0080);
        issue(LSU_TYPE_LBU, 32'h8000_0003, 32'h0);
        serve(0, 0, 32'h80FF_0011, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        collect(0);

        // stores
        exp_q.push_back(32'h0);
        issue(LSU_TYPE_SH, 32'h8000_0002, 32'hAAAA_BEEF);
        serve(0, 1, 32'h0, 32'h8000_0000, 1'b1, 32'hBEEF_BEEF, 4'b1100);
        collect(0);
        exp_q.push_back(32'h0);
        issue(LSU_TYPE_SB, 32'h8000_0041, 32'h1234_56A5);
        serve(0, 0, 32'h0, 32'h8000_0040, 1'b1, 32'hA5A5_A5A5, 4'b0010);
        collect(0);
        exp_q.push_back(32'h0);
        issue(LSU_TYPE_SW, 32'h8000_0044, 32'h0BAD_F00D);
        serve(0, 0, 32'h0, 32'h8000_0044, 1'b1, 32'h0BAD_F00D, 4'b1111);
        collect(0);

        // assorted loads against the reference model
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ld_model(lt[i], la[i], lw_[i]));
            issue(lt[i], la[i], 32'h0);
            serve(0, i % 2, lw_[i], {la[i][31:2], 2'b00}, 1'b0, 32'h0, 4'h0);
            collect(0);
        end

        // backpressure on both memory and write-back sides
        exp_q.push_back(32'hCAFE_F00D);
        issue(LSU_TYPE_LW, 32'h8000_0010, 32'h0);
        serve(3, 1, 32'hCAFE_F00D, 32'h8000_0010, 1'b0, 32'h0, 4'h0);
        collect(2);

        // unknown code behaves as pass-through
        exp_q.push_back(32'h0BAD_CAFE);
        issue(4'hF, 32'h0BAD_CAFE, 32'h0);
        chk("unk_no_req", {31'h0, req_valid}, 32'h0);
        collect(0);

        // reset while waiting for the response
        issue(LSU_TYPE_LW, 32'h8000_0020, 32'h0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_req_valid", {31'h0, req_valid}, 32'h0);
        chk("rstw_ready", {31'h0, lsu_ready}, 32'h1);
        chk("rstw_sys_valid", {31'h0, sys_valid}, 32'h0);
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data  = '0;
        chk("stale_resp", {31'h0, sys_valid}, 32'h0);
        @(negedge clk);
        chk("stale_resp2", {31'h0, sys_valid}, 32'h0);
        chk("stale_ready", {31'h0, lsu_ready}, 32'h1);

        // operation after reset still works
        exp_q.push_back(32'h0000_0055);
        issue(LSU_TYPE_LBU, 32'h8000_0031, 32'h0);
        serve(0, 0, 32'h0000_5500, 32'h8000_0030, 1'b0, 32'h0, 4'h0);
        collect(0);

`ifdef LSU_MISALIGN_CHECK_EN
        issue(LSU_TYPE_LW, 32'h8000_0002, 32'h0);
        chk("mis_valid", {31'h0, sys_valid}, 32'h1);
        chk("mis_no_req", {31'h0, req_valid}, 32'h0);
        chk("mis_flag", {31'h0, misalign}, 32'h1);
        chk("mis_res", lsu_res, 32'h8000_0002);
        sys_ready = 1'b1;
        @(negedge clk);
        sys_ready = 1'b0;
        chk("mis_clear", {31'h0, misalign}, 32'h0);
        chk("mis_ready", {31'h0, lsu_ready}, 32'h1);
`endif

        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
